// File: rtl/apb_rr_master_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_arb_pkg
// Description : Shared types and helpers for the round-robin APB master
//               arbiter: FSM state encoding, default bus widths and a
//               one-hot to index conversion.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } arb_state_e;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  // Index of the set bit in a one-hot vector of up to 8 bits (0 if none).
  function automatic int onehot2idx(input logic [7:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick. Searches the eligible vector
//               upward from pointer+1 with wrap-around and returns the first
//               set bit.
// Ports       : eligible   - candidate requesters
//               pointer    - index of the last winner
//               winner_oh  - one-hot winner
//               winner_idx - binary winner index
//               any_valid  - at least one requester eligible
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IDX_W-1:0]   pointer,
  output logic [NUM_REQ-1:0] winner_oh,
  output logic [IDX_W-1:0]   winner_idx,
  output logic               any_valid
);

  always_comb begin
    int cand;
    cand       = 0;
    winner_oh  = '0;
    winner_idx = '0;
    any_valid  = 1'b0;
    // Offset 1 first so the previous winner is considered last.
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(pointer) + k) % NUM_REQ;
      if (!any_valid && eligible[cand]) begin
        winner_oh[cand] = 1'b1;
        winner_idx      = IDX_W'(cand);
        any_valid       = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/apb_rr_master_arb.sv
`default_nettype none
// ============================================================================
// Module      : apb_rr_master_arb
// Description : Round-robin sharing of one APB master port among NUM_REQ
//               requesters. Each grant runs SETUP then ACCESS, and completion
//               plus read data are returned to the owner as a one-cycle done.
// Ports       : pclk/preset            - clock, synchronous active-high reset
//               req/req_write/req_addr/req_wdata - packed requester inputs
//               gnt/done/rdata         - owner, completion pulse, read data
//               psel/penable/pwrite/paddr/pwdata/prdata - APB master port
//               pready                 - only with APB_ARB_PREADY_EN defined
// Options     : APB_ARB_PREADY_EN - adds pready wait states in ACCESS
// Revision    : 1.0 - initial release
// ============================================================================
module apb_rr_master_arb
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W
) (
  input  logic                      pclk,
  input  logic                      preset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rdata,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDR_W-1:0]         paddr,
  output logic [DATA_W-1:0]         pwdata,
  input  logic [DATA_W-1:0]         prdata
`ifdef APB_ARB_PREADY_EN
  ,
  input  logic                      pready
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e         r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [NUM_REQ-1:0] w_eligible;
  logic [NUM_REQ-1:0] w_win_oh;
  logic [IDX_W-1:0]   w_win_idx;
  logic               w_any;
  logic               w_complete;
  logic [7:0]         w_gnt_ext;

  logic [ADDR_W-1:0]  w_addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]  w_wdata_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign w_addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
    assign w_wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
  end

  // A requester still holding req during its done cycle must not re-win.
  assign w_eligible = req & ~done;

`ifdef APB_ARB_PREADY_EN
  assign w_complete = pready;
`else
  assign w_complete = 1'b1;
`endif

  always_comb begin
    w_gnt_ext              = '0;
    w_gnt_ext[NUM_REQ-1:0] = gnt;
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .eligible   (w_eligible),
    .pointer    (r_ptr),
    .winner_oh  (w_win_oh),
    .winner_idx (w_win_idx),
    .any_valid  (w_any)
  );

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state <= IDLE;
      r_ptr   <= IDX_W'(NUM_REQ - 1);
      gnt     <= '0;
      done    <= '0;
      rdata   <= '0;
      psel    <= 1'b0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
    end else begin
      done <= '0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            gnt     <= w_win_oh;
            paddr   <= w_addr_arr[w_win_idx];
            pwdata  <= w_wdata_arr[w_win_idx];
            pwrite  <= req_write[w_win_idx];
            psel    <= 1'b1;
            penable <= 1'b0;
            r_state <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          r_state <= ACCESS;
        end
        ACCESS: begin
          // Without the pready option w_complete is tied high.
          if (w_complete) begin
            rdata   <= prdata;
            done    <= gnt;
            r_ptr   <= IDX_W'(onehot2idx(w_gnt_ext));
            psel    <= 1'b0;
            penable <= 1'b0;
            gnt     <= '0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_rr_master_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_rr_master_arb
// Description : Directed self-checking bench for apb_rr_master_arb
//               (NUM_REQ=4, 32-bit address and data).
// Options     : APB_ARB_PREADY_EN - adds the pready wait-state scenario
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_rr_master_arb;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;

  logic                      pclk;
  logic                      preset;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        done;
  logic [DATA_W-1:0]         rdata;
  logic                      psel;
  logic                      penable;
  logic                      pwrite;
  logic [ADDR_W-1:0]         paddr;
  logic [DATA_W-1:0]         pwdata;
  logic [DATA_W-1:0]         prdata;
`ifdef APB_ARB_PREADY_EN
  logic                      pready;
`endif

  int n_vec;
  int n_err;

  apb_rr_master_arb #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W)
  ) dut (
    .pclk      (pclk),
    .preset    (preset),
    .req       (req),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .done      (done),
    .rdata     (rdata),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata)
`ifdef APB_ARB_PREADY_EN
    ,
    .pready    (pready)
`endif
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Advance one clock; checks and new drives happen 1 time unit after the edge.
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic [3:0] e_gnt, input logic e_psel,
                         input logic e_pen, input logic [3:0] e_done);
    chk({tag, ".gnt"},     64'(gnt),     64'(e_gnt));
    chk({tag, ".psel"},    64'(psel),    64'(e_psel));
    chk({tag, ".penable"}, 64'(penable), 64'(e_pen));
    chk({tag, ".done"},    64'(done),    64'(e_done));
  endtask

  initial begin
    logic [3:0] exp_oh;
    n_vec     = 0;
    n_err     = 0;
    preset    = 1'b1;
    req       = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    prdata    = 32'hA5A5_0001;
`ifdef APB_ARB_PREADY_EN
    pready    = 1'b1;
`endif

    // ---- reset state
    tick();
    tick();
    chk_bus("rst", 4'b0000, 1'b0, 1'b0, 4'b0000);
    chk("rst.rdata",  64'(rdata),  64'(0));
    chk("rst.paddr",  64'(paddr),  64'(0));
    chk("rst.pwdata", 64'(pwdata), 64'(0));
    chk("rst.pwrite", 64'(pwrite), 64'(0));
    preset = 1'b0;

    // ---- single write from requester 1
    req[1]               = 1'b1;
    req_write[1]         = 1'b1;
    req_addr[1*32 +: 32] = 32'h10;
    req_wdata[1*32 +: 32]= 32'hDEADBEEF;
    tick();
    chk_bus("wr.setup", 4'b0010, 1'b1, 1'b0, 4'b0000);
    chk("wr.setup.paddr",  64'(paddr),  64'h10);
    chk("wr.setup.pwdata", 64'(pwdata), 64'hDEADBEEF);
    chk("wr.setup.pwrite", 64'(pwrite), 64'(1));
    tick();
    chk_bus("wr.access", 4'b0010, 1'b1, 1'b1, 4'b0000);
    chk("wr.access.paddr",  64'(paddr),  64'h10);
    chk("wr.access.pwdata", 64'(pwdata), 64'hDEADBEEF);
    tick();
    chk_bus("wr.done", 4'b0000, 1'b0, 1'b0, 4'b0010);
    chk("wr.done.paddr_hold", 64'(paddr), 64'h10);
    req = '0;
    tick();
    chk_bus("wr.idle", 4'b0000, 1'b0, 1'b0, 4'b0000);

    // ---- single read from requester 2
    req[2]               = 1'b1;
    req_write[2]         = 1'b0;
    req_addr[2*32 +: 32] = 32'h20;
    tick();
    chk_bus("rd.setup", 4'b0100, 1'b1, 1'b0, 4'b0000);
    chk("rd.setup.paddr",  64'(paddr),  64'h20);
    chk("rd.setup.pwrite", 64'(pwrite), 64'(0));
    tick();
    chk_bus("rd.access", 4'b0100, 1'b1, 1'b1, 4'b0000);
    chk("rd.access.pwrite", 64'(pwrite), 64'(0));
    tick();
    chk_bus("rd.done", 4'b0000, 1'b0, 1'b0, 4'b0100);
    chk("rd.done.rdata", 64'(rdata), 64'hA5A5_0001);
    req = '0;
    tick();

    // ---- simultaneous requests 1 and 3 from reset
    preset = 1'b1;
    tick();
    preset = 1'b0;
    req_addr[3*32 +: 32] = 32'h30;
    req_write[3]         = 1'b1;
    req = 4'b1010;
    tick();
    chk_bus("sim.first", 4'b0010, 1'b1, 1'b0, 4'b0000);
    tick();
    tick();
    chk_bus("sim.done1", 4'b0000, 1'b0, 1'b0, 4'b0010);
    req = 4'b1000;
    tick();
    chk_bus("sim.second", 4'b1000, 1'b1, 1'b0, 4'b0000);
    chk("sim.second.paddr", 64'(paddr), 64'h30);
    tick();
    tick();
    chk_bus("sim.done3", 4'b0000, 1'b0, 1'b0, 4'b1000);
    req = '0;
    tick();

    // ---- continuous all-request fairness, from reset
    preset = 1'b1;
    tick();
    preset = 1'b0;
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      exp_oh = 4'b0001 << (k % 4);
      tick();
      chk_bus($sformatf("rr%0d.setup", k), exp_oh, 1'b1, 1'b0, 4'b0000);
      tick();
      chk_bus($sformatf("rr%0d.access", k), exp_oh, 1'b1, 1'b1, 4'b0000);
      tick();
      chk_bus($sformatf("rr%0d.done", k), 4'b0000, 1'b0, 1'b0, exp_oh);
    end
    req = '0;
    tick();

    // ---- reset in the ACCESS cycle of a requester-2 read
    req = 4'b0100;
    tick();
    chk_bus("ab.setup", 4'b0100, 1'b1, 1'b0, 4'b0000);
    tick();
    chk_bus("ab.access", 4'b0100, 1'b1, 1'b1, 4'b0000);
    preset = 1'b1;
    tick();
    chk_bus("ab.reset", 4'b0000, 1'b0, 1'b0, 4'b0000);
    preset = 1'b0;
    req = 4'b0110;
    tick();
    chk_bus("ab.regrant", 4'b0010, 1'b1, 1'b0, 4'b0000);
    tick();
    tick();
    chk_bus("ab.done1", 4'b0000, 1'b0, 1'b0, 4'b0010);
    req = 4'b0100;
    tick();
    chk_bus("ab.next2", 4'b0100, 1'b1, 1'b0, 4'b0000);
    tick();
    tick();
    chk_bus("ab.done2", 4'b0000, 1'b0, 1'b0, 4'b0100);
    req = '0;
    tick();

`ifdef APB_ARB_PREADY_EN
    // ---- write with three pready-low ACCESS cycles
    pready               = 1'b0;
    req_write[0]         = 1'b1;
    req_addr[0*32 +: 32] = 32'h40;
    req_wdata[0*32 +: 32]= 32'h1234_5678;
    req = 4'b0001;
    tick();
    chk_bus("rdy.setup", 4'b0001, 1'b1, 1'b0, 4'b0000);
    for (int w = 0; w < 4; w++) begin
      tick();
      chk_bus($sformatf("rdy.access%0d", w), 4'b0001, 1'b1, 1'b1, 4'b0000);
      chk($sformatf("rdy.access%0d.paddr", w),  64'(paddr),  64'h40);
      chk($sformatf("rdy.access%0d.pwdata", w), 64'(pwdata), 64'h1234_5678);
      if (w == 3) pready = 1'b1;
    end
    tick();
    chk_bus("rdy.done", 4'b0000, 1'b0, 1'b0, 4'b0001);
    req = '0;
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
